serial_adder: RTL
=================

# serial_adder

Parametrised multi-cycle adder: adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, through a DIGIT-bit full-adder chain and a registered carry. Trades latency for area against the single-cycle full_adder, and is the arithmetic building block for the team's area-constrained datapaths. A start/busy/done handshake frames each operation. Results are held stable until the next operation completes.

## Interface
- WIDTH, 8, operand and sum width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits added per clock; 1 ≤ DIGIT ≤ WIDTH.
- N (localparam), WIDTH/DIGIT, number of RUN cycles.

- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- in1  input  WIDTH  operand A; sampled with start.
- in2  input  WIDTH  operand B; sampled with start.
- c_in  input  1  carry-in; sampled with start.
- sub  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when sum/c_out are updated.
- sum  output  WIDTH  result, registered.
- c_out  output  1  carry-out of bit WIDTH-1, registered.

## Operation
- FSM states: IDLE, RUN, DONE. Digit counter: ceil(log2(N)) bits, or 1 bit when N=1.
- IDLE: busy=0, done=0. If start=1, capture in1, in2 and c_in into the A, B and carry registers, clear the counter, and go to RUN.
- RUN: busy=1. Each cycle:
  - add A[DIGIT-1:0] + B[DIGIT-1:0] + carry;
  - shift the DIGIT-bit result into the top of the partial-sum register and shift A and B right by DIGIT;
  - update carry and increment the counter.
  - On the cycle with counter = N-1, write sum and c_out and go to DONE.
- DONE: busy=0, done=1 for exactly this cycle. start=1 here is accepted exactly as in IDLE (go to RUN, capture operands); otherwise go to IDLE.
- start while busy=1 is ignored: no queueing and no effect on the operation in flight.
- in1, in2 and c_in may change freely after capture.
- sum/c_out change only on the edge that enters DONE, so partial results are never visible.
- Arithmetic: {c_out, sum} = in1 + in2 + c_in, modulo 2^(WIDTH+1).

## Timing
- Start accepted at edge E0 → RUN at E1..EN → done=1 during the cycle after EN.
- Latency is N clocks from the accepting edge to done high.
- Back-to-back throughput is one result per N+1 cycles when start is held high.
- Reset (rst_n=0, any time, including mid-RUN):
  - state IDLE, counter 0, carry 0;
  - busy=0, done=0, sum=0, c_out=0;
  - the in-flight operation is discarded with no done pulse.
- Reset release: the first start can be accepted on the first rising edge with rst_n=1.
- N=1 (DIGIT=WIDTH): single RUN cycle; the block degenerates to a registered full adder with a 1-cycle latency.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - sub port exists and is sampled with start.
  - sub=1 computes in1 − in2 as in1 + ~in2 + 1, with c_in ignored. c_out=1 means no borrow.
  - sub=0 behaves as add.
- SERIAL_ADDER_SUB_EN undefined: no sub port; add only, with no inversion logic synthesised.

## Test plan
- Reset: assert rst_n=0 → busy=0, done=0, sum=8'h00, c_out=0. Release, idle 3 cycles → no done pulse.
- Basic add (WIDTH=8, DIGIT=2): in1=8'h5A, in2=8'h3C, c_in=0, start 1 cycle → done exactly 4 cycles after the accepting edge; sum=8'h96, c_out=0; busy high 4 cycles.
- Carry chain: 8'hFF+8'h01+0 → sum=8'h00, c_out=1. Then 8'hFF+8'hFF+1 → sum=8'hFF, c_out=1.
- Handshake: start held high through a 8'h01+8'h02 operation, with operands changed mid-RUN → result 8'h03 unaffected; new operation accepted in the DONE cycle; done pulses every 5 cycles.
- Reset mid-op: rst_n=0 two cycles into RUN → outputs 0 immediately; no done pulse. Next operation 8'h10+8'h20 → 8'h30.
- SERIAL_ADDER_SUB_EN: sub=1, 8'h10−8'h20 → sum=8'hF0, c_out=0. 8'h20−8'h10 → sum=8'h10, c_out=1.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// The sub select exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output start, in1, in2, c_in,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, in1, in2, c_in,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        output busy, done, sum, c_out
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder: DIGIT bits per clock through a registered carry, N = WIDTH/DIGIT cycles.
// Optional subtract mode (in1 + ~in2 + 1) is built only when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] psum_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             c_out_r;
    logic             busy_r;
    logic             done_r;

    logic             load_s;
    logic             last_s;
    logic [DIGIT:0]   digit_s;
    logic [WIDTH-1:0] psum_next_s;
    logic [WIDTH-1:0] b_load_s;
    logic             carry_load_s;

    // Operand conditioning at capture: subtract folds into B inversion plus forced carry-in.
    always_comb begin
        b_load_s     = bus.in2;
        carry_load_s = bus.c_in;
`ifdef SERIAL_ADDER_SUB_EN
        if (bus.sub) begin
            b_load_s     = ~bus.in2;
            carry_load_s = 1'b1;
        end else begin
            b_load_s     = bus.in2;
            carry_load_s = bus.c_in;
        end
`endif
    end

    // One digit of the full-adder chain, and the partial sum with the new digit shifted in at the top.
    always_comb begin
        digit_s     = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + (DIGIT+1)'(carry_r);
        psum_next_s = (psum_r >> DIGIT) | (WIDTH'(digit_s[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    // Next-state logic; DONE accepts a new start exactly like IDLE.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next_s = RUN;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CW'(N - 1)) begin
                    state_next_s = DONE;
                    last_s       = 1'b1;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and registered outputs; sum/c_out are written only on the edge entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CW{1'b0}};
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            psum_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            sum_r   <= {WIDTH{1'b0}};
            c_out_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            busy_r <= (state_next_s == RUN);
            done_r <= (state_next_s == DONE);
            if (load_s) begin
                a_r     <= bus.in1;
                b_r     <= b_load_s;
                carry_r <= carry_load_s;
                cnt_r   <= {CW{1'b0}};
                psum_r  <= {WIDTH{1'b0}};
            end else if (state_r == RUN) begin
                a_r     <= a_r >> DIGIT;
                b_r     <= b_r >> DIGIT;
                carry_r <= digit_s[DIGIT];
                cnt_r   <= cnt_r + CW'(1);
                psum_r  <= psum_next_s;
            end else begin
                cnt_r   <= cnt_r;
            end
            if (last_s) begin
                sum_r   <= psum_next_s;
                c_out_r <= digit_s[DIGIT];
            end else begin
                sum_r   <= sum_r;
            end
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.sum   = sum_r;
    assign bus.c_out = c_out_r;
endmodule
